ssd_scan_scheduler: RTL
=======================

Name: ssd_scan_scheduler

Overview:
Time-multiplexes the board's eight 7-segment digits between two requesters. The primary requester is the game status value (score and health nibbles), shown continuously. The overlay requester is a message source that takes the display for a programmed number of frames. The block drives the active-low anode and cathode pins directly, inserts a dead-time guard between digits, and switches source only at frame boundaries so no frame tears.

Parameters:
SCAN_DIV, 131072, clk cycles per digit slot (ON plus guard); must be greater than GUARD.
GUARD, 256, cycles at the end of each slot with all anodes off (anti-ghosting).

Ports:
clk  input  1  system clock (100 MHz)
rst_n  input  1  asynchronous, active-low reset
a_digits  input  32  primary nibbles; [3:0] is digit 0 (rightmost), [31:28] is digit 7
a_dp  input  8  primary decimal points, 1 = lit
a_lzs  input  1  leading-zero suppression enable for primary source
b_req  input  1  overlay request, level, held until b_ack
b_digits  input  32  overlay nibbles, captured on accept
b_hold  input  8  overlay duration in frames, captured on accept
b_ack  output  1  one-cycle accept pulse
b_busy  output  1  overlay accepted and not yet finished
an  output  8  anodes, active-low, an[i] drives digit i
seg  output  8  {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low
frame_tick  output  1  one-cycle pulse at start of each frame
src_is_b  output  1  current frame shows overlay

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - an=8'hFF, seg=8'hFF, b_ack=0, b_busy=0, frame_tick=0, src_is_b=0.
  - Slot counter=0, digit index=7, scan state=GUARD, overlay state=IDLE, snapshot=0.
- Scan FSM has two states, ON and GUARD.
  - ON lasts SCAN_DIV-GUARD cycles: an[idx]=0, all other anodes 1, seg = decode of snapshot nibble idx.
  - GUARD lasts GUARD cycles: an=8'hFF, seg=8'hFF.
  - GUARD→ON advances idx modulo 8 (7 wraps to 0).
- Frame boundary is the GUARD→ON transition where idx wraps 7→0. In that same cycle:
  - frame_tick pulses.
  - Source is chosen: B if overlay state is PEND or SHOW, else A.
  - The 32-bit digits, dp (8'h00 for B) and lzs (0 for B) are snapshotted from the chosen source.
  - src_is_b updates.
  - Snapshot is held for the entire frame; input changes mid-frame have no effect until the next boundary.
- First frame after reset begins SCAN_DIV-... specifically after GUARD cycles (reset enters GUARD at idx 7).
- Decode (abcdefg, active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, B=1100000, C=0110001, D=1000010, E=0110000, F=0111000
  - Dp bit = ~dp[idx].
- Leading-zero suppression (when the snapshotted lzs is 1):
  - Digit i (i≥1) is blanked (seg=8'hFF, anode still driven) if nibbles i..7 are all zero.
  - Digit 0 is never suppressed.
- Overlay FSM:
  - IDLE: if b_req=1, capture b_digits and b_hold, pulse b_ack next cycle, go to PEND. A captured b_hold of 0 is treated as 1.
  - PEND: wait for a frame boundary, then go to SHOW. The frame counter loads the hold value at that boundary.
  - SHOW: decrement at each subsequent frame boundary. When the count reaches 0 at a boundary, go to IDLE in that cycle. That boundary snapshots A, so overlay shows exactly hold frames.
  - b_busy=1 in PEND and SHOW.
  - b_req while busy: ignored, no ack, no recapture; requester keeps it asserted.
  - b_req held high across the SHOW→IDLE transition: re-accepted on the following cycle. The new overlay starts at the next boundary, so at least one A frame intervenes.
- Simultaneous b_req acceptance and frame boundary in the same cycle: the accept is registered first and the state is still IDLE at the boundary, so that frame is A.
- Async reset mid-frame or mid-overlay: all state returns to reset values immediately, and the overlay is dropped without ack.
- Latency: a_digits change → visible at the next frame boundary (≤8·SCAN_DIV cycles).

Test Plan:
1. Reset and first frame (SCAN_DIV=16, GUARD=4, a_digits=32'h0000_0A05, lzs=0):
   - an=FF during reset and for the 4 cycles after release.
   - Then an=FE with seg=8'h49 ("5") for 12 cycles.
   - frame_tick pulses once; digit 1 shows seg=8'h11 ("A").
2. Guard and rotation: count cycles over 2 frames → each an[i] is low for exactly 12 of every 128 cycles, never two anodes low together, an=FF for 4 cycles between slots, idx order 0..7.
3. Leading-zero suppression (a_digits=32'h0000_0120, lzs=1):
   - Digits 0,1,2 show 0,2,1.
   - Digits 3–7 show seg=FF while their anode is driven.
   - a_digits=0 → only digit 0 shows "0".
4. Overlay (b_req=1, b_digits=32'hDEAD_BEEF, b_hold=2, issued mid-frame):
   - b_ack pulses once, b_busy=1.
   - Current frame stays A.
   - Next 2 frames src_is_b=1 showing F,E,E,B,D,A,E,D.
   - Then A; b_busy falls at that boundary.
5. Hold edge cases:
   - b_hold=0 → exactly 1 overlay frame.
   - b_req held high throughout → ack, 1 overlay frame, ≥1 A frame, ack again.
   - b_req during SHOW → no ack until IDLE.
6. Mid-frame changes and reset:
   - a_digits changed mid-frame → no visible change until next frame_tick.
   - rst_n pulsed low during SHOW → an=FF, b_busy=0, src_is_b=0 immediately.
   - Recovery frame shows A.

Source files
------------

// File: rtl/ssd_scan_scheduler.sv
// Eight-digit 7-segment scan scheduler.
// A primary source (game status) is shown continuously; an overlay source can
// take the display for a programmed number of whole frames. Anodes and
// cathodes are active-low; every digit slot ends with a dead-time guard where
// all anodes are off. The displayed source and its data are latched only at
// frame boundaries, so a frame never mixes two sources or two data values.
//
// Handshake (overlay): b_req is a level held by the requester until it sees
// b_ack. While the block is idle, a b_req high at a rising clk edge is
// accepted: b_digits/b_hold are captured on that edge, b_ack is high for
// exactly the following cycle, and b_busy stays high until the overlay has
// finished. b_req seen while b_busy is high is ignored; there is no
// back-pressure other than withholding b_ack.
module ssd_scan_scheduler #(
  parameter int SCAN_DIV = 131072,
  parameter int GUARD    = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a_digits,
  input  logic [7:0]  a_dp,
  input  logic        a_lzs,
  input  logic        b_req,
  input  logic [31:0] b_digits,
  input  logic [7:0]  b_hold,
  output logic        b_ack,
  output logic        b_busy,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_tick,
  output logic        src_is_b
);

  localparam int ON_LEN = SCAN_DIV - GUARD;
  localparam int CW     = $clog2(SCAN_DIV);

  typedef enum logic {
    S_ON    = 1'b0,
    S_GUARD = 1'b1
  } scan_state_t;

  typedef enum logic [1:0] {
    O_IDLE = 2'd0,
    O_PEND = 2'd1,
    O_SHOW = 2'd2
  } ovl_state_t;

  // Scan state
  scan_state_t scan_state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;

  // Frame snapshot of the chosen source
  logic [31:0] snap_digits;
  logic [7:0]  snap_dp;
  logic        snap_lzs;

  // Overlay state and captured request
  ovl_state_t  ovl_state;
  logic [7:0]  ovl_cnt;
  logic [31:0] ovl_digits;
  logic [7:0]  ovl_hold;

  // Next-state values
  scan_state_t nxt_scan_state;
  logic [CW-1:0] nxt_cnt;
  logic [2:0]    nxt_idx;
  logic [31:0]   nxt_snap_digits;
  logic [7:0]    nxt_snap_dp;
  logic          nxt_snap_lzs;
  logic [7:0]    nxt_an;
  logic [7:0]    nxt_seg;
  logic          boundary;
  logic          pick_b;
  logic          last_on;
  logic          last_guard;

  // Segment pattern {a,b,c,d,e,f,g} for a hex nibble, active-low
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Full cathode byte for digit i, including leading-zero blanking.
  // Digit i>=1 blanks when it and every digit to its left are zero.
  function automatic logic [7:0] digit_seg(input logic [31:0] d,
                                           input logic [7:0]  dp,
                                           input logic        lzs,
                                           input logic [2:0]  i);
    logic [4:0]  sh;
    logic [3:0]  nib;
    logic [31:0] upper;
    logic [7:0]  r;
    sh    = {i, 2'b00};
    nib   = d[sh +: 4];
    upper = d >> sh;
    if (lzs && (i != 3'd0) && (upper == 32'd0))
      r = 8'hFF;
    else
      r = {hex_to_seg(nib), ~dp[i]};
    return r;
  endfunction

  // Scan sequencing, frame-boundary source selection and next pin values
  always_comb begin
    nxt_scan_state  = scan_state;
    nxt_cnt         = cnt;
    nxt_idx         = idx;
    nxt_snap_digits = snap_digits;
    nxt_snap_dp     = snap_dp;
    nxt_snap_lzs    = snap_lzs;
    nxt_an          = 8'hFF;
    nxt_seg         = 8'hFF;

    last_on    = (cnt == CW'(ON_LEN - 1));
    last_guard = (cnt == CW'(GUARD - 1));

    case (scan_state)
      S_ON: begin
        if (last_on) begin
          nxt_scan_state = S_GUARD;
          nxt_cnt        = '0;
        end else begin
          nxt_cnt = cnt + CW'(1);
        end
      end
      default: begin
        if (last_guard) begin
          nxt_scan_state = S_ON;
          nxt_cnt        = '0;
          nxt_idx        = idx + 3'd1;
        end else begin
          nxt_cnt = cnt + CW'(1);
        end
      end
    endcase

    boundary = (scan_state == S_GUARD) && last_guard && (idx == 3'd7);

    // The last SHOW frame is the one where the count would reach zero; that
    // boundary already hands the display back to the primary source.
    pick_b = (ovl_state == O_PEND) ||
             ((ovl_state == O_SHOW) && (ovl_cnt != 8'd1));

    if (boundary) begin
      if (pick_b) begin
        nxt_snap_digits = ovl_digits;
        nxt_snap_dp     = 8'h00;
        nxt_snap_lzs    = 1'b0;
      end else begin
        nxt_snap_digits = a_digits;
        nxt_snap_dp     = a_dp;
        nxt_snap_lzs    = a_lzs;
      end
    end

    if (nxt_scan_state == S_ON) begin
      nxt_an  = ~(8'b0000_0001 << nxt_idx);
      nxt_seg = digit_seg(nxt_snap_digits, nxt_snap_dp, nxt_snap_lzs, nxt_idx);
    end
  end

  // Scan registers, snapshot and registered display pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_state  <= S_GUARD;
      cnt         <= '0;
      idx         <= 3'd7;
      snap_digits <= 32'd0;
      snap_dp     <= 8'd0;
      snap_lzs    <= 1'b0;
      an          <= 8'hFF;
      seg         <= 8'hFF;
      frame_tick  <= 1'b0;
      src_is_b    <= 1'b0;
    end else begin
      scan_state  <= nxt_scan_state;
      cnt         <= nxt_cnt;
      idx         <= nxt_idx;
      snap_digits <= nxt_snap_digits;
      snap_dp     <= nxt_snap_dp;
      snap_lzs    <= nxt_snap_lzs;
      an          <= nxt_an;
      seg         <= nxt_seg;
      frame_tick  <= boundary;
      if (boundary)
        src_is_b <= pick_b;
    end
  end

  // Overlay request FSM: accept, wait for a boundary, show for hold frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovl_state  <= O_IDLE;
      ovl_cnt    <= 8'd0;
      ovl_digits <= 32'd0;
      ovl_hold   <= 8'd0;
      b_ack      <= 1'b0;
      b_busy     <= 1'b0;
    end else begin
      b_ack <= 1'b0;
      case (ovl_state)
        O_IDLE: begin
          if (b_req) begin
            ovl_digits <= b_digits;
            ovl_hold   <= (b_hold == 8'd0) ? 8'd1 : b_hold;
            b_ack      <= 1'b1;
            b_busy     <= 1'b1;
            ovl_state  <= O_PEND;
          end
        end
        O_PEND: begin
          if (boundary) begin
            ovl_cnt   <= ovl_hold;
            ovl_state <= O_SHOW;
          end
        end
        O_SHOW: begin
          if (boundary) begin
            if (ovl_cnt == 8'd1) begin
              ovl_cnt   <= 8'd0;
              ovl_state <= O_IDLE;
              b_busy    <= 1'b0;
            end else begin
              ovl_cnt <= ovl_cnt - 8'd1;
            end
          end
        end
        default: begin
          ovl_state <= O_IDLE;
          b_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
